// File: rtl/lcd_ctrl_if.sv
// lcd_ctrl_if -- LSU-side store/status bundle for the HD44780 controller.
//   lcd_wr_i   : one-cycle store strobe for the LCD address (LSU -> controller)
//   lcd_data_i : store word, [31]=ON, [9]=RS, [7:0]=byte (LSU -> controller)
//   busy_o     : controller has queued or in-flight work (controller -> LSU)
//   full_o     : 4-entry command FIFO is full (controller -> LSU)
//   ovf_o      : sticky flag, a store was dropped while full (controller -> LSU)
interface lcd_ctrl_if #(
  parameter int unsigned n = 32
);
  logic         lcd_wr_i;
  logic [n-1:0] lcd_data_i;
  logic         busy_o;
  logic         full_o;
  logic         ovf_o;

  modport master (output lcd_wr_i, lcd_data_i, input busy_o, full_o, ovf_o);
  modport slave  (input lcd_wr_i, lcd_data_i, output busy_o, full_o, ovf_o);
endinterface

// File: rtl/lcd_ctrl.sv
// lcd_ctrl -- HD44780 write-only controller fed by LSU stores.
// Buffers {ON, RS, byte} words in a 4-entry FIFO, waits for power-up, sends
// the fixed init sequence, then plays each word out as SETUP/PULSE/HOLD/EXEC.
//   clk_i, rst_ni          : clock, asynchronous active-low reset
//   lsu (slave)            : store strobe/word in, busy/full/ovf status out
//   lcd_on_o, lcd_rs_o     : backlight/power enable, register select
//   lcd_rw_o, lcd_en_o     : read/write (always write), enable strobe
//   lcd_data_o             : 8-bit data bus
module lcd_ctrl #(
  parameter int unsigned n       = 32,
  parameter int unsigned T_PWR   = 2_000_000,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_EN    = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2_500,
  parameter int unsigned T_LONG  = 82_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  lcd_ctrl_if.slave  lsu,
  output logic       lcd_on_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic [7:0] lcd_data_o
);

  localparam int unsigned ON_BIT = (n > 31) ? 31 : n - 1;

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n, limit;
  logic [1:0]  init_idx, init_idx_n;
  logic        init_done, init_done_n;
  logic        expired, load_init, long_exec;
  logic [7:0]  init_byte;

  // FIFO of {ON, RS, byte}
  logic [9:0]  mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count, count_n;
  logic        full, empty, ovf;
  logic        push, pop;

  // Space is judged on the registered flag, so a same-cycle pop never admits a push.
  assign push    = lsu.lcd_wr_i & ~full;
  assign pop     = (state == IDLE) & ~empty;
  assign count_n = count + {2'b00, push} - {2'b00, pop};

  assign long_exec = ~lcd_rs_o && (lcd_data_o >= 8'h01) && (lcd_data_o <= 8'h03);

  always_comb begin
    init_byte = 8'h38;
    case (init_idx)
      2'd0: init_byte = 8'h38;
      2'd1: init_byte = 8'h0C;
      2'd2: init_byte = 8'h01;
      2'd3: init_byte = 8'h06;
      default: init_byte = 8'h38;
    endcase
  end

  always_comb begin
    limit = 32'd1;
    case (state)
      PWR_WAIT: limit = T_PWR;
      SETUP:    limit = T_SETUP;
      PULSE:    limit = T_EN;
      HOLD:     limit = T_HOLD;
      EXEC:     limit = long_exec ? T_LONG : T_EXEC;
      default:  limit = 32'd1;
    endcase
  end

  assign expired = (cnt == limit - 32'd1);

  always_comb begin
    state_n     = state;
    init_idx_n  = init_idx;
    init_done_n = init_done;
    load_init   = 1'b0;
    cnt_n       = expired ? '0 : cnt + 32'd1;
    case (state)
      PWR_WAIT: if (expired) state_n = INIT;
      INIT: begin
        load_init = 1'b1;
        cnt_n     = '0;
        state_n   = SETUP;
      end
      IDLE: begin
        cnt_n = '0;
        if (!empty) state_n = SETUP;
      end
      SETUP: if (expired) state_n = PULSE;
      PULSE: if (expired) state_n = HOLD;
      HOLD:  if (expired) state_n = EXEC;
      EXEC: begin
        if (expired) begin
          if (init_done) begin
            state_n = IDLE;
          end else if (init_idx == 2'd3) begin
            init_done_n = 1'b1;
            state_n     = IDLE;
          end else begin
            init_idx_n = init_idx + 2'd1;
            state_n    = INIT;
          end
        end
      end
      default: state_n = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= PWR_WAIT;
      cnt       <= '0;
      init_idx  <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      init_idx  <= init_idx_n;
      init_done <= init_done_n;
    end
  end

  // EN is registered from the next state so it is high exactly while in PULSE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lcd_en_o   <= 1'b0;
      lcd_rs_o   <= 1'b0;
      lcd_data_o <= '0;
      lcd_on_o   <= 1'b0;
    end else begin
      lcd_en_o <= (state_n == PULSE);
      if (state == PWR_WAIT) lcd_on_o <= 1'b1;
      if (load_init) begin
        lcd_on_o   <= 1'b1;
        lcd_rs_o   <= 1'b0;
        lcd_data_o <= init_byte;
      end else if (pop) begin
        {lcd_on_o, lcd_rs_o, lcd_data_o} <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count_n;
      full  <= (count_n == 3'd4);
      empty <= (count_n == 3'd0);
      if (lsu.lcd_wr_i && full) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {lsu.lcd_data_i[ON_BIT], lsu.lcd_data_i[9], lsu.lcd_data_i[7:0]};
  end

  assign lcd_rw_o   = 1'b0;
  assign lsu.busy_o = ~((state == IDLE) && empty);
  assign lsu.full_o = full;
  assign lsu.ovf_o  = ovf;

endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl -- directed bench for lcd_ctrl with short timing parameters
// (T_PWR=10, T_SETUP=2, T_EN=4, T_HOLD=2, T_EXEC=8, T_LONG=20).
// Cycle numbers are counted in clock edges after reset release.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       on, rs, rw, en;
  logic [7:0] data;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int b;

  lcd_ctrl_if #(.n(32)) bus ();

  lcd_ctrl #(
    .n(32), .T_PWR(10), .T_SETUP(2), .T_EN(4), .T_HOLD(2), .T_EXEC(8), .T_LONG(20)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .lsu(bus),
    .lcd_on_o(on),
    .lcd_rs_o(rs),
    .lcd_rw_o(rw),
    .lcd_en_o(en),
    .lcd_data_o(data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [31:0] word);
    bus.lcd_wr_i   = 1'b1;
    bus.lcd_data_i = word;
    step();
    bus.lcd_wr_i   = 1'b0;
  endtask

  // Wait for the next EN rise, then check rise cycle, bus contents, width and hold.
  task automatic pulse(input string tag, input int exp_rise, input logic [7:0] exp_byte,
                       input logic exp_rs, input logic exp_on);
    bit ok;
    int w;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({tag, "_rise"}, cyc, exp_rise);
      chk({tag, "_data"}, 32'(data), 32'(exp_byte));
      chk({tag, "_rs"}, 32'(rs), 32'(exp_rs));
      chk({tag, "_on"}, 32'(on), 32'(exp_on));
      chk({tag, "_rw"}, 32'(rw), 32'd0);
      w = 0;
      for (int i = 0; i < 50; i++) begin
        if (en !== 1'b1) break;
        w++;
        step();
      end
      chk({tag, "_width"}, w, 4);
      chk({tag, "_hold_data"}, 32'(data), 32'(exp_byte));
      chk({tag, "_hold_rs"}, 32'(rs), 32'(exp_rs));
    end
  endtask

  // Wait for busy to drop; no further EN pulse may appear on the way.
  task automatic wait_idle(input string tag, input int exp_t);
    bit   ok;
    int   rises;
    logic prev;
    ok    = 1'b0;
    rises = 0;
    prev  = en;
    for (int i = 0; i < 300; i++) begin
      if (bus.busy_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
      if (en === 1'b1 && prev !== 1'b1) rises++;
      prev = en;
    end
    chk({tag, "_idle_seen"}, 32'(ok), 32'd1);
    chk({tag, "_idle_at"}, cyc, exp_t);
    chk({tag, "_extra_pulses"}, rises, 0);
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bus.lcd_wr_i   = 1'b0;
    bus.lcd_data_i = '0;

    // Reset state
    repeat (3) step();
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_rs", 32'(rs), 32'd0);
    chk("rst_rw", 32'(rw), 32'd0);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_on", 32'(on), 32'd0);
    chk("rst_full", 32'(bus.full_o), 32'd0);
    chk("rst_ovf", 32'(bus.ovf_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd1);

    // Power-up wait and init sequence
    rst_n = 1'b1;
    cyc   = 0;
    step();
    chk("pwr_on", 32'(on), 32'd1);
    chk("pwr_busy", 32'(bus.busy_o), 32'd1);
    chk("pwr_en", 32'(en), 32'd0);
    pulse("init38", 13, 8'h38, 1'b0, 1'b1);
    pulse("init0c", 30, 8'h0C, 1'b0, 1'b1);
    pulse("init01", 47, 8'h01, 1'b0, 1'b1);
    pulse("init06", 76, 8'h06, 1'b0, 1'b1);
    wait_idle("init", 90);

    // Single data write
    write(32'h8000_0241);
    b = cyc;
    chk("wr_busy", 32'(bus.busy_o), 32'd1);
    pulse("w41", b + 3, 8'h41, 1'b1, 1'b1);
    wait_idle("w41", b + 17);

    // Long vs short execution wait for byte 0x01
    write(32'h0000_0001);
    b = cyc;
    pulse("clr", b + 3, 8'h01, 1'b0, 1'b0);
    wait_idle("clr", b + 29);
    write(32'h0000_0201);
    b = cyc;
    pulse("rs01", b + 3, 8'h01, 1'b1, 1'b0);
    wait_idle("rs01", b + 17);

    // Five back-to-back writes while busy: fourth fills, fifth overflows
    write(32'h8000_0230);
    b = cyc;
    pulse("a30", b + 3, 8'h30, 1'b1, 1'b1);
    bus.lcd_wr_i   = 1'b1;
    bus.lcd_data_i = 32'h8000_0231;
    step();
    bus.lcd_data_i = 32'h8000_0080;
    step();
    bus.lcd_data_i = 32'h8F00_FE33;
    step();
    chk("full_after3", 32'(bus.full_o), 32'd0);
    bus.lcd_data_i = 32'h8000_0234;
    step();
    chk("full_after4", 32'(bus.full_o), 32'd1);
    chk("ovf_after4", 32'(bus.ovf_o), 32'd0);
    bus.lcd_data_i = 32'h8000_0235;
    step();
    bus.lcd_wr_i   = 1'b0;
    chk("ovf_after5", 32'(bus.ovf_o), 32'd1);
    chk("full_after5", 32'(bus.full_o), 32'd1);
    pulse("b31", b + 20, 8'h31, 1'b1, 1'b1);
    chk("full_after_pop", 32'(bus.full_o), 32'd0);
    chk("ovf_sticky", 32'(bus.ovf_o), 32'd1);
    pulse("b80", b + 37, 8'h80, 1'b0, 1'b1);
    pulse("b33", b + 54, 8'h33, 1'b1, 1'b1);
    pulse("b34", b + 71, 8'h34, 1'b1, 1'b1);
    wait_idle("burst", b + 85);

    // Reset during PULSE with queued words, then writes during power-up wait
    write(32'h8000_02AA);
    b = cyc;
    write(32'h8000_02BB);
    write(32'h8000_02CC);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (en === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    chk("xaa_seen", 32'(ok), 32'd1);
    chk("xaa_rise", cyc, b + 3);
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(en), 32'd0);
    chk("arst_data", 32'(data), 32'h00);
    chk("arst_rs", 32'(rs), 32'd0);
    chk("arst_on", 32'(on), 32'd0);
    chk("arst_full", 32'(bus.full_o), 32'd0);
    chk("arst_ovf", 32'(bus.ovf_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd1);
    #2;
    rst_n = 1'b1;
    cyc   = 0;
    step();
    chk("rel_on", 32'(on), 32'd1);
    bus.lcd_wr_i   = 1'b1;
    bus.lcd_data_i = 32'h8000_0255;
    step();
    bus.lcd_data_i = 32'h0000_0066;
    step();
    bus.lcd_wr_i   = 1'b0;
    pulse("re38", 13, 8'h38, 1'b0, 1'b1);
    pulse("re0c", 30, 8'h0C, 1'b0, 1'b1);
    pulse("re01", 47, 8'h01, 1'b0, 1'b1);
    pulse("re06", 76, 8'h06, 1'b0, 1'b1);
    pulse("q55", 93, 8'h55, 1'b1, 1'b1);
    pulse("q66", 110, 8'h66, 1'b0, 1'b0);
    wait_idle("replay", 124);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
